// File: rtl/mul16_seq_ctrl.sv
// rtl/mul16_seq_ctrl.sv - iterative 16x16 shift-and-add multiplier sequencing one cla_16.
// Optional early termination on exhausted multiplier bits: define MUL_EARLY_TERM_EN.

module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        p,
  output logic        g
);
  // Carries out of each bit of a 4-bit group, bit 3 is the group carry out.
  function automatic logic [3:0] la4(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
    logic [3:0] c;
    c[0] = gi[0] | (pi[0] & ci);
    c[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    c[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
    c[3] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0])
         | (pi[3] & pi[2] & pi[1] & pi[0] & ci);
    return c;
  endfunction

  logic [15:0] gb, pb, cbit;
  logic [3:0]  gg, gp, grp_c, bit_c, top_c;
  logic [4:0]  nc;

  always_comb begin
    gb    = a & b;
    pb    = a ^ b;
    gg    = '0;
    gp    = '0;
    cbit  = '0;
    bit_c = '0;
    for (int k = 0; k < 4; k++) begin
      bit_c = la4(gb[4*k +: 4], pb[4*k +: 4], 1'b0);
      gg[k] = bit_c[3];
      gp[k] = &pb[4*k +: 4];
    end
    grp_c = la4(gg, gp, cin);
    nc    = {grp_c, cin};
    for (int k = 0; k < 4; k++) begin
      bit_c = la4(gb[4*k +: 4], pb[4*k +: 4], nc[k]);
      cbit[4*k +: 4] = {bit_c[2:0], nc[k]};
    end
    top_c = la4(gg, gp, 1'b0);
    s     = pb ^ cbit;
    cout  = nc[4];
    p     = &gp;
    g     = top_c[3];
  end
endmodule

module mul16_seq_ctrl #(
  parameter int ITERS = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
  localparam int ALIGN = 16 - ITERS;

  logic [1:0]       state;
  logic [15:0]      mcand;
  logic [31:0]      acc;
  logic [CNT_W-1:0] count;

  logic [15:0] addend, sum;
  logic        cout, unused_p, unused_g;
  logic [31:0] acc_next, final_product;
  logic        finish;

  assign addend = acc[0] ? mcand : 16'd0;

  cla_16 u_cla (
    .a    (acc[31:16]),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout),
    .p    (unused_p),
    .g    (unused_g)
  );

  // Carry lands in bit 31 as the accumulator shifts right, so no carry is lost.
  assign acc_next = {cout, sum, acc[15:1]};

`ifdef MUL_EARLY_TERM_EN
  localparam logic [15:0] B_MASK = 16'hFFFF >> ALIGN;
  logic [CNT_W-1:0] left;
  logic [15:0]      rem_mask;
  logic [4:0]       shamt;

  // Unconsumed in-range multiplier bits sit at acc_next[left-1:0].
  assign left          = LAST - count;
  assign rem_mask      = 16'((17'd1 << left) - 17'd1);
  assign finish        = (acc_next[15:0] & rem_mask) == 16'd0;
  assign shamt         = 5'd15 - 5'(count);
  assign final_product = acc_next >> shamt;
`else
  assign finish        = (count == LAST);
  assign final_product = acc_next >> ALIGN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {16'd0, b};
            count <= '0;
`ifdef MUL_EARLY_TERM_EN
            if ((b & B_MASK) == 16'd0) begin
              product <= '0;
              state   <= S_DONE;
            end else begin
              state   <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count + CNT_W'(1);
          if (finish) begin
            product <= final_product;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN) || (state == S_DONE);
  assign done  = (state == S_DONE);
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// tb/tb_mul16_seq_ctrl.sv - randomized and directed bench for mul16_seq_ctrl.
// Follows MUL_EARLY_TERM_EN when defined so the reference latency matches the build.

module tb_mul16_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready, busy, done;
  logic [31:0] product;

  int vectors = 0;
  int miscompares = 0;

  mul16_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_product(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Clock edges from the accepting edge until done is visible.
  function automatic int ref_latency(input logic [15:0] y);
`ifdef MUL_EARLY_TERM_EN
    for (int i = 15; i >= 0; i--)
      if (y[i]) return i + 1;
    return 0;
`else
    return 16;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Waits for done with a bounded budget and checks latency/product/pulse width.
  task automatic wait_done(input string name, input logic [15:0] ta, input logic [15:0] tb_);
    int  lat = 0;
    bit  seen = 0;
    logic [31:0] exp_p = ref_product(ta, tb_);
    while (!seen && lat <= 40) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_timeout: done never seen within %0d cycles", name, lat);
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(ref_latency(tb_)));
      chk({name, "_product"}, product, exp_p);
      chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic exec(input string name, input logic [15:0] ta, input logic [15:0] tb_);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    chk({name, "_ready_drop"}, {31'd0, ready}, 32'd0);
    wait_done(name, ta, tb_);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, "_ready_back"}, {31'd0, ready}, 32'd1);
    chk({name, "_product_hold"}, product, ref_product(ta, tb_));
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    exec("small_3x5", 16'd3, 16'd5);
    exec("max_ffff", 16'hFFFF, 16'hFFFF);
    exec("zero_b", 16'h1234, 16'h0000);
    exec("msb_a_b1", 16'h8000, 16'h0001);
    exec("msb_b", 16'h8000, 16'h8000);
  endtask

  task automatic test_hold_start;
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    a = 16'd2; b = 16'd2;
    chk("hold_ready_drop", {31'd0, ready}, 32'd0);
    wait_done("hold_first", 16'd7, 16'd9);
    @(posedge clk); #1;
    chk("hold_single_done", {31'd0, done}, 32'd0);
    chk("hold_ready_back", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_second_accept", {31'd0, ready}, 32'd0);
    wait_done("hold_second", 16'd2, 16'd2);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int spurious = 0;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) spurious++;
    end
    chk("abort_no_done", 32'(spurious), 32'd0);
    exec("after_abort", 16'h00FF, 16'h0101);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 16);
      exec("random", ra, rb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
